tau_chain_scheduler: RTL and testbench

//  Sequences the shared Transform Acceleration Unit datapath between a direct (abc->dq) and an inverse (dq->abc) requester.

---
 rtl/tau_chain_scheduler_pkg.sv | 38 +++
 rtl/tau_chain_scheduler_if.sv | 39 +++
 rtl/tau_chain_scheduler_rr_arbiter.sv | 34 +++
 rtl/tau_chain_scheduler.sv | 157 +++++++++++++++
 tb/tb_tau_chain_scheduler.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/tau_chain_scheduler_pkg.sv
// rtl/tau_chain_scheduler_pkg.sv - shared types for the TAU chain scheduler
package tau_chain_scheduler_pkg;

  typedef enum logic [1:0] {
    OP_CLARKE      = 2'd0,
    OP_PARK        = 2'd1,
    OP_ANTI_PARK   = 2'd2,
    OP_ANTI_CLARKE = 2'd3
  } tau_op_t;

  typedef struct packed {
    logic requester;
    logic stage;
  } tau_tag_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_COMPLETE
  } sched_state_t;

  localparam logic REQ_DIRECT  = 1'b0;
  localparam logic REQ_INVERSE = 1'b1;

  // Stage 0 is the first transform of each direction, stage 1 the chained follow-up.
  function automatic tau_op_t stage_op(input logic requester, input logic stage);
    tau_op_t op;
    case ({requester, stage})
      2'b00:   op = OP_CLARKE;
      2'b01:   op = OP_PARK;
      2'b10:   op = OP_ANTI_PARK;
      default: op = OP_ANTI_CLARKE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/tau_chain_scheduler_if.sv
// rtl/tau_chain_scheduler_if.sv - request, op issue, result and done signals of the scheduler
interface tau_chain_scheduler_if #(
  parameter int DEST_WIDTH = 4
) ();
  import tau_chain_scheduler_pkg::*;

  logic                  direct_req_valid;
  logic                  direct_req_ready;
  logic [DEST_WIDTH-1:0] direct_req_dest;
  logic                  inverse_req_valid;
  logic                  inverse_req_ready;
  logic [DEST_WIDTH-1:0] inverse_req_dest;
  logic                  op_valid;
  logic                  op_ready;
  tau_op_t               op_code;
  tau_tag_t              op_tag;
  logic                  result_valid;
  tau_tag_t              result_tag;
  logic                  done_valid;
  logic                  done_requester;
  logic [DEST_WIDTH-1:0] done_dest;

  // Scheduler side.
  modport slave (
    input  direct_req_valid, direct_req_dest, inverse_req_valid, inverse_req_dest,
    input  op_ready, result_valid, result_tag,
    output direct_req_ready, inverse_req_ready, op_valid, op_code, op_tag,
    output done_valid, done_requester, done_dest
  );

  // Requesters plus datapath side.
  modport master (
    output direct_req_valid, direct_req_dest, inverse_req_valid, inverse_req_dest,
    output op_ready, result_valid, result_tag,
    input  direct_req_ready, inverse_req_ready, op_valid, op_code, op_tag,
    input  done_valid, done_requester, done_dest
  );

endinterface

// File: rtl/tau_chain_scheduler_rr_arbiter.sv
// rtl/tau_chain_scheduler_rr_arbiter.sv - two-way round-robin arbiter, grant bit0 direct, bit1 inverse
module tau_rr_arbiter_2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_q;
  logic last_d;

  always_comb begin
    grant  = valid;
    last_d = last_q;
    // On contention the side not granted last time wins.
    if (valid == 2'b11) begin
      grant = last_q ? 2'b01 : 2'b10;
    end
    if (advance) begin
      last_d = grant[1];
    end
  end

  // Reset value "inverse granted last" makes direct the preferred side.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/tau_chain_scheduler.sv
// rtl/tau_chain_scheduler.sv - shares the TAU datapath between direct and inverse requesters
module tau_chain_scheduler
  import tau_chain_scheduler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int DEST_WIDTH     = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        soft_reset,
  input  logic                        disable_direct_chain_mode,
  input  logic                        disable_inverse_chain_mode,
  tau_chain_scheduler_if.slave        bus,
  output logic                        busy,
  output logic                        err_timeout,
  output logic                        err_tag
);

  localparam int                 CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  sched_state_t          state_q, state_d;
  logic                  req_q, req_d;
  logic [DEST_WIDTH-1:0] dest_q, dest_d;
  logic                  nochain_q, nochain_d;
  logic                  stage_q, stage_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_timeout_q, err_timeout_d;
  logic                  err_tag_q, err_tag_d;

  logic       flush;
  logic [1:0] arb_valid;
  logic [1:0] grant;
  logic       accept;
  tau_tag_t   cur_tag;
  logic       match;

  assign flush = reset | soft_reset;

  // Requests are only offered in IDLE and never while a flush is in progress,
  // so a handshake can not be swallowed by the flush.
  assign arb_valid = {bus.inverse_req_valid, bus.direct_req_valid}
                   & {2{(state_q == ST_IDLE) && !flush}};
  assign accept    = |grant;

  tau_rr_arbiter_2 u_arb (
    .clock   (clock),
    .reset   (flush),
    .valid   (arb_valid),
    .advance (accept),
    .grant   (grant)
  );

  assign bus.direct_req_ready  = grant[0];
  assign bus.inverse_req_ready = grant[1];

  assign cur_tag = '{requester: req_q, stage: stage_q};
  assign match   = bus.result_valid && (bus.result_tag == cur_tag);

  assign busy        = (state_q != ST_IDLE);
  assign err_timeout = err_timeout_q;
  assign err_tag     = err_tag_q;

  always_comb begin
    state_d            = state_q;
    req_d              = req_q;
    dest_d             = dest_q;
    nochain_d          = nochain_q;
    stage_d            = stage_q;
    cnt_d              = cnt_q;
    err_timeout_d      = err_timeout_q;
    err_tag_d          = err_tag_q;
    bus.op_valid       = 1'b0;
    bus.op_code        = OP_CLARKE;
    bus.op_tag         = '0;
    bus.done_valid     = 1'b0;
    bus.done_requester = 1'b0;
    bus.done_dest      = '0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_d     = grant[1] ? REQ_INVERSE : REQ_DIRECT;
          dest_d    = grant[1] ? bus.inverse_req_dest : bus.direct_req_dest;
          nochain_d = grant[1] ? disable_inverse_chain_mode : disable_direct_chain_mode;
          stage_d   = 1'b0;
          state_d   = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        bus.op_valid = 1'b1;
        bus.op_code  = stage_op(req_q, stage_q);
        bus.op_tag   = cur_tag;
        if (bus.op_ready) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A matching result beats a timeout expiring in the same cycle.
        if (match) begin
          if (!stage_q && !nochain_q) begin
            stage_d = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_COMPLETE;
          end
        end else begin
          if (bus.result_valid) begin
            err_tag_d = 1'b1;
          end
          if (cnt_q == CNT_LAST) begin
            err_timeout_d = 1'b1;
            state_d       = ST_IDLE;
          end
        end
      end

      ST_COMPLETE: begin
        bus.done_valid     = 1'b1;
        bus.done_requester = req_q;
        bus.done_dest      = dest_q;
        state_d            = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (flush) begin
      state_q       <= ST_IDLE;
      req_q         <= 1'b0;
      dest_q        <= '0;
      nochain_q     <= 1'b0;
      stage_q       <= 1'b0;
      cnt_q         <= '0;
      err_timeout_q <= 1'b0;
      err_tag_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      dest_q        <= dest_d;
      nochain_q     <= nochain_d;
      stage_q       <= stage_d;
      cnt_q         <= cnt_d;
      err_timeout_q <= err_timeout_d;
      err_tag_q     <= err_tag_d;
    end
  end

endmodule

// File: tb/tb_tau_chain_scheduler.sv
// tb/tb_tau_chain_scheduler.sv - directed and randomized checks of tau_chain_scheduler against a transaction model
module tb_tau_chain_scheduler;
  import tau_chain_scheduler_pkg::*;

  localparam int TMO = 16;

  logic clock = 1'b0;
  logic reset;
  logic soft_reset;
  logic ddis;
  logic idis;
  logic busy;
  logic err_timeout;
  logic err_tag;

  tau_chain_scheduler_if #(.DEST_WIDTH(4)) bus ();

  tau_chain_scheduler #(.TIMEOUT_CYCLES(TMO), .DEST_WIDTH(4)) dut (
    .clock                      (clock),
    .reset                      (reset),
    .soft_reset                 (soft_reset),
    .disable_direct_chain_mode  (ddis),
    .disable_inverse_chain_mode (idis),
    .bus                        (bus),
    .busy                       (busy),
    .err_timeout                (err_timeout),
    .err_tag                    (err_tag)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  int done_cnt = 0;
  int both_ready_cnt = 0;
  bit last_grant;

  always @(negedge clock) begin
    if (bus.done_valid) done_cnt++;
    if (bus.direct_req_ready && bus.inverse_req_ready) both_ready_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // mode: 0 normal, 1 wrong tag before first result, 2 no result (timeout), 3 soft_reset in first WAIT
  task automatic do_txn(input bit dv, input bit iv, input bit dd_dis, input bit id_dis,
                        input logic [3:0] dd, input logic [3:0] id, input int lat, input int mode);
    bit w;
    bit dis;
    logic [3:0] dst;
    int nops;
    int dones0;
    int n;
    int stall;
    logic [1:0] ecode;
    logic [1:0] etag;

    bus.direct_req_valid  = dv;
    bus.inverse_req_valid = iv;
    bus.direct_req_dest   = dd;
    bus.inverse_req_dest  = id;
    ddis = dd_dis;
    idis = id_dis;
    #1;
    w   = (dv && iv) ? ~last_grant : iv;
    dis = w ? id_dis : dd_dis;
    dst = w ? id : dd;
    chk("direct_req_ready", bus.direct_req_ready, !w);
    chk("inverse_req_ready", bus.inverse_req_ready, w);
    tick();
    last_grant = w;
    bus.direct_req_valid  = 1'b0;
    bus.inverse_req_valid = 1'b0;
    bus.direct_req_dest   = 4'($urandom);
    bus.inverse_req_dest  = 4'($urandom);
    ddis = 1'($urandom);
    idis = 1'($urandom);
    nops   = dis ? 1 : 2;
    dones0 = done_cnt;

    for (int s = 0; s < nops; s++) begin
      ecode = w ? ((s == 1) ? 2'd3 : 2'd2) : ((s == 1) ? 2'd1 : 2'd0);
      etag  = {w, s[0]};
      n = 0;
      while (!bus.op_valid && n < 8) begin
        tick();
        n++;
      end
      chk("op_valid", bus.op_valid, 1);
      stall = $urandom_range(0, 2);
      repeat (stall) begin
        chk("op_code_hold", bus.op_code, ecode);
        tick();
      end
      chk("op_code", bus.op_code, ecode);
      chk("op_tag", bus.op_tag, etag);
      bus.op_ready = 1'b1;
      tick();
      bus.op_ready = 1'b0;
      if (s == 0 && mode == 2) begin
        repeat (TMO - 1) tick();
        chk("busy_before_timeout", busy, 1);
        chk("err_timeout_before", err_timeout, 0);
        tick();
        chk("busy_after_timeout", busy, 0);
        chk("err_timeout_after", err_timeout, 1);
        chk("no_done_on_timeout", done_cnt, dones0);
        return;
      end
      if (s == 0 && mode == 3) begin
        soft_reset = 1'b1;
        tick();
        soft_reset = 1'b0;
        chk("busy_after_soft_reset", busy, 0);
        chk("err_timeout_cleared", err_timeout, 0);
        chk("err_tag_cleared", err_tag, 0);
        bus.result_valid = 1'b1;
        bus.result_tag   = etag;
        tick();
        bus.result_valid = 1'b0;
        chk("late_result_no_err_tag", err_tag, 0);
        chk("late_result_idle", busy, 0);
        chk("late_result_no_done", done_cnt, dones0);
        last_grant = 1'b1;
        return;
      end
      if (s == 0 && mode == 1) begin
        bus.result_valid = 1'b1;
        bus.result_tag   = 2'b11;
        tick();
        bus.result_valid = 1'b0;
        chk("err_tag_set", err_tag, 1);
        chk("busy_after_bad_tag", busy, 1);
        chk("no_reissue_bad_tag", bus.op_valid, 0);
      end
      repeat (lat) tick();
      bus.result_valid = 1'b1;
      bus.result_tag   = etag;
      tick();
      bus.result_valid = 1'b0;
    end

    chk("done_valid", bus.done_valid, 1);
    chk("done_requester", bus.done_requester, w);
    chk("done_dest", bus.done_dest, dst);
    tick();
    chk("done_pulse_width", bus.done_valid, 0);
    chk("idle_after_done", busy, 0);
    chk("no_extra_op", bus.op_valid, 0);
    chk("one_done", done_cnt, dones0 + 1);
  endtask

  initial begin
    reset = 1'b1;
    soft_reset = 1'b0;
    ddis = 1'b0;
    idis = 1'b0;
    bus.direct_req_valid  = 1'b0;
    bus.inverse_req_valid = 1'b0;
    bus.direct_req_dest   = '0;
    bus.inverse_req_dest  = '0;
    bus.op_ready     = 1'b0;
    bus.result_valid = 1'b0;
    bus.result_tag   = '0;
    last_grant = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    chk("reset_busy", busy, 0);
    chk("reset_op_valid", bus.op_valid, 0);
    chk("reset_done_valid", bus.done_valid, 0);
    chk("reset_done_dest", bus.done_dest, 0);
    chk("reset_err_timeout", err_timeout, 0);
    chk("reset_err_tag", err_tag, 0);
    chk("reset_ready", {bus.direct_req_ready, bus.inverse_req_ready}, 0);

    do_txn(1, 0, 0, 0, 4'd5, 4'd0, 2, 0);
    do_txn(0, 1, 0, 1, 4'd0, 4'd9, 3, 0);
    do_txn(1, 0, 1, 0, 4'd12, 4'd0, TMO - 1, 0);
    chk("result_beats_timeout", err_timeout, 0);

    for (int k = 0; k < 4; k++) begin
      do_txn(1, 1, 0, 0, 4'(k), 4'(k + 8), $urandom_range(0, 4), 0);
    end

    do_txn(1, 0, 0, 0, 4'd3, 4'd0, 1, 1);
    do_txn(1, 0, 0, 0, 4'd7, 4'd0, 0, 2);
    do_txn(0, 1, 0, 0, 4'd0, 4'd14, 1, 0);
    do_txn(1, 0, 0, 0, 4'd2, 4'd0, 0, 3);

    for (int k = 0; k < 30; k++) begin
      bit dv;
      bit iv;
      dv = 1'($urandom);
      iv = 1'($urandom);
      if (!dv && !iv) dv = 1'b1;
      do_txn(dv, iv, 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
             $urandom_range(0, TMO - 1), 0);
    end
    chk("err_timeout_random_phase", err_timeout, 0);
    chk("err_tag_random_phase", err_tag, 0);
    chk("never_both_ready", both_ready_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
